// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and fetches one 16-bit word per request
// over a req/ack memory handshake, substituting a NOP if memory hangs.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0000,
  parameter int          MAX_WAIT     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        set_pc,
  input  logic [15:0] jump_target,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam bit TMO_EN = (MAX_WAIT > 0);
  localparam logic [CW-1:0] LAST =
    TMO_EN ? CW'(MAX_WAIT - 1) : '0;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t          state, state_d;
  logic            mem_req_d;
  logic [15:0]     mem_addr_d;
  logic [15:0]     instr_d;
  logic            instr_valid_d;
  logic [15:0]     pc_d;
  logic            busy_d;
  logic            fetch_err_d;
  logic [CW-1:0]   wait_cnt, wait_cnt_d;

  always_comb begin
    state_d       = state;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    pc_d          = pc;
    busy_d        = busy;
    fetch_err_d   = fetch_err;
    wait_cnt_d    = wait_cnt;
    unique case (state)
      IDLE: begin
        if (fetch_start) begin
          state_d       = REQ;
          mem_addr_d    = pc;
          mem_req_d     = 1'b1;
          busy_d        = 1'b1;
          instr_valid_d = 1'b0;
          fetch_err_d   = 1'b0;
          wait_cnt_d    = '0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d       = IDLE;
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          mem_req_d     = 1'b0;
          busy_d        = 1'b0;
          pc_d          = pc + 16'd1;
        end else if (TMO_EN && wait_cnt == LAST) begin
          state_d       = IDLE;
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b1;
          fetch_err_d   = 1'b1;
          mem_req_d     = 1'b0;
          busy_d        = 1'b0;
        end else begin
          wait_cnt_d    = wait_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A jump overrides the post-fetch increment but never the live request.
    if (set_pc) pc_d = jump_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= 16'h0000;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc          <= RESET_VECTOR;
      busy        <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      pc          <= pc_d;
      busy        <= busy_d;
      fetch_err   <= fetch_err_d;
      wait_cnt    <= wait_cnt_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the control unit. Owns the program counter and fetches one 16-bit instruction per fetch request from instruction memory over a req/ack handshake.
- Holds the fetched word stable on instr until the next fetch completes. The control unit decodes it across its DECODE/EXECUTE/STORE states.
- Accepts the control unit's set_pc jump strobe, with the target taken from register A.
- Includes a bounded-wait timeout that substitutes a NOP on a memory hang.

Parameters:
RESET_VECTOR, 16'h0000, PC value after reset
NOP_INSTR, 16'h0000, instruction word substituted on fetch timeout
MAX_WAIT, 16, max cycles mem_req stays high without mem_ack before abort; 0 disables timeout

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
fetch_start  input  1  request next fetch; sampled only in IDLE
set_pc  input  1  jump strobe from control unit
jump_target  input  16  jump destination (register A value)
mem_req  output  1  instruction memory request, held until ack or abort
mem_addr  output  16  fetch address, stable while mem_req high
mem_ack  input  1  memory returns mem_rdata valid this cycle
mem_rdata  input  16  instruction word from memory
instr  output  16  last fetched instruction, to control unit
instr_valid  output  1  instr holds a completed fetch not yet superseded
pc  output  16  current program counter
busy  output  1  high while in REQ state
fetch_err  output  1  last fetch ended by timeout

Behaviour:
- Reset is asynchronous and active-high. The clock is clk, the reset is rst, and there is one clock domain.
- Reset values:
  - pc=RESET_VECTOR
  - state=IDLE
  - mem_req=0, mem_addr=0
  - instr=NOP_INSTR, instr_valid=0
  - busy=0, fetch_err=0
  - wait_cnt=0
- Reset asserted mid-request drops mem_req immediately, without waiting for an edge. Any in-flight ack is lost.
- FSM has two states:
  - IDLE: on posedge with fetch_start=1, register mem_addr<=pc, mem_req<=1, busy<=1, instr_valid<=0, fetch_err<=0, wait_cnt<=0, and go to REQ. With fetch_start=0, all outputs hold.
  - REQ, ack path: on posedge with mem_ack=1, register instr<=mem_rdata, instr_valid<=1, mem_req<=0, busy<=0, pc<=pc+1 (16-bit wrap, FFFF->0000), and go to IDLE.
  - REQ, no ack, MAX_WAIT!=0 and wait_cnt==MAX_WAIT-1: abort. Register instr<=NOP_INSTR, instr_valid<=1, fetch_err<=1, mem_req<=0, busy<=0, leave pc unchanged, and go to IDLE.
  - REQ, otherwise: wait_cnt<=wait_cnt+1 and hold all other state.
- fetch_start while in REQ is ignored; it is not queued.
- mem_ack outside REQ is ignored.
- Minimum latency is 2 edges: fetch_start sampled at edge N, mem_req visible after N, ack sampled at N+1, instr_valid high after N+1.
- mem_addr and mem_req change only at the REQ entry or exit edges.
- set_pc=1 on any posedge (IDLE or REQ) sets pc<=jump_target.
  - set_pc has priority over the ack increment at the same edge.
  - set_pc does not abort an in-flight request. The fetched word is still delivered, but the pc+1 increment is discarded.
  - set_pc has no effect on mem_addr of the current request.
- pc is a plain registered output and is never combinationally bypassed.
- wait_cnt must be wide enough to hold MAX_WAIT-1.

Test Plan:
1. Reset, then fetch_start pulse; mem_rdata=16'h8123 with ack on the first REQ cycle. Expected: mem_addr=0000, instr=8123 and instr_valid=1 two edges after start, pc=0001, busy low.
2. Ack delayed by 5 cycles with MAX_WAIT=16. Expected: mem_req and mem_addr stable for all 6 REQ cycles, extra fetch_start pulses ignored, a single pc increment.
3. No ack with MAX_WAIT=4. Expected: mem_req drops after 4 cycles, instr=NOP_INSTR, fetch_err=1, pc unchanged. The next fetch_start clears fetch_err and refetches the same address.
4. set_pc=1 with jump_target=16'h0040 on the same edge as mem_ack. Expected: pc=0040 (not +1), instr captured. With set_pc in IDLE, the next mem_addr=0040.
5. pc=FFFF, completed fetch. Expected: pc wraps to 0000.
6. rst asserted mid-REQ between edges. Expected: mem_req=0, busy=0, instr_valid=0, pc=RESET_VECTOR immediately; a stale ack after reset release is ignored.
